// File: rtl/tone_det_pkg.sv
// Shared constants and helpers for the Goertzel tone detector.
// Holds the FSM state encodings, the default coefficient fraction,
// the result-width helper and the saturating-clip helpers.
package tone_det_pkg;

    // Default number of fractional bits of the Q3.15 coefficient
    localparam int unsigned COEF_FRAC_DEF = 15;

    // Working width used by the saturation helpers; wide enough for any
    // intermediate sum the datapath can form
    localparam int unsigned SAT_MAX_W = 128;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_PWR1  = 3'd2;
    localparam logic [2:0] ST_PWR2  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Width of the squared-magnitude result for a given state width
    function automatic int unsigned power_w(input int unsigned acc_w);
        return 2 * acc_w + 2;
    endfunction

    // Clip v to the signed range of a w-bit value
    function automatic logic signed [SAT_MAX_W-1:0] sat_clip(
        input logic signed [SAT_MAX_W-1:0] v,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    // True when v lies outside the signed range of a w-bit value
    function automatic logic sat_hit(
        input logic signed [SAT_MAX_W-1:0] v,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/goertzel_step.sv
// One combinational Goertzel recurrence step:
//   s_new = sat(x + ((coef*s1) >>> COEF_FRAC) - s2)
// Ports:
//   i_x      sample, signed DATA_W
//   i_s1     previous state s[n-1], signed ACC_W
//   i_s2     state s[n-2], signed ACC_W
//   i_coef   2*cos(w), signed COEF_W with COEF_FRAC fractional bits
//   o_s_new  new state, saturated to signed ACC_W
//   o_sat    the unsaturated result was out of range
module goertzel_step
    import tone_det_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
    parameter int unsigned ACC_W     = 40
) (
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [ACC_W-1:0]  i_s1,
    input  logic signed [ACC_W-1:0]  i_s2,
    input  logic signed [COEF_W-1:0] i_coef,
    output logic signed [ACC_W-1:0]  o_s_new,
    output logic                     o_sat
);

    localparam int unsigned PROD_W = ACC_W + COEF_W;
    // Two guard bits so x + fb - s2 cannot wrap before the clip
    localparam int unsigned SUM_W  = PROD_W + 2;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_fb;
    logic signed [SUM_W-1:0]  w_sum;

    // Full-precision product, then floor-scaled back to state units
    assign w_prod = PROD_W'(i_coef) * PROD_W'(i_s1);
    assign w_fb   = w_prod >>> COEF_FRAC;
    assign w_sum  = SUM_W'(i_x) + SUM_W'(w_fb) - SUM_W'(i_s2);

    assign o_s_new = ACC_W'(sat_clip(SAT_MAX_W'(w_sum), ACC_W));
    assign o_sat   = sat_hit(SAT_MAX_W'(w_sum), ACC_W);

endmodule

// File: rtl/goertzel_tone_detector.sv
// Goertzel single-bin detector: accumulates a block of N samples and
// reports |X[k]|^2 = s1^2 + s2^2 - coef*s1*s2 for downstream gain math.
// Optional build macro: TONE_IQ_OUT_EN adds sin_coef, m_re and m_im.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a block (IDLE only), latches block_len/coef
//   block_len, coef   block length N (0 ignored), 2*cos(2*pi*k/N) Q3.15
//   sin_coef          sin(2*pi*k/N) Q3.15 (TONE_IQ_OUT_EN only)
//   s_data, s_valid,
//   s_ready           sample stream; s_ready high only while accumulating
//   m_power, m_sat,
//   m_valid, m_ready  result stream; result held until m_ready
//   m_re, m_im        bin real/imag parts (TONE_IQ_OUT_EN only)
//   busy              detector is not idle
module goertzel_tone_detector
    import tone_det_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned LEN_W     = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN_W-1:0]              block_len,
    input  logic signed [COEF_W-1:0]      coef,
`ifdef TONE_IQ_OUT_EN
    input  logic signed [COEF_W-1:0]      sin_coef,
    output logic signed [ACC_W:0]         m_re,
    output logic signed [ACC_W:0]         m_im,
`endif
    input  logic signed [DATA_W-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [power_w(ACC_W)-1:0]     m_power,
    output logic                          m_sat,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy
);

    localparam int unsigned PWR_W   = power_w(ACC_W);
    localparam int unsigned SQ_W    = 2 * ACC_W;
    localparam int unsigned FB_W    = ACC_W + COEF_W;
    localparam int unsigned X_W     = FB_W + ACC_W;
    localparam int unsigned P_SUM_W = X_W + 2;

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic [LEN_W-1:0]          r_n;
    logic [LEN_W-1:0]          r_count;
    logic signed [COEF_W-1:0]  r_coef;
    logic signed [ACC_W-1:0]   r_s1;
    logic signed [ACC_W-1:0]   r_s2;
    logic signed [ACC_W-1:0]   w_s_new;
    logic                      r_sat;
    logic                      w_step_sat;
    logic                      w_start;
    logic                      w_accept;
    logic                      w_last;
    logic signed [SQ_W-1:0]    r_sq1;
    logic signed [SQ_W-1:0]    r_sq2;
    logic signed [FB_W-1:0]    w_fb1;
    logic signed [X_W-1:0]     r_cross;
    logic signed [P_SUM_W-1:0] w_psum;

    assign w_start  = (r_state == ST_IDLE) && start && (block_len != '0);
    assign w_accept = (r_state == ST_ACCUM) && s_valid;
    assign w_last   = w_accept && ((r_count + LEN_W'(1)) == r_n);

    goertzel_step #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_step (
        .i_x     (s_data),
        .i_s1    (r_s1),
        .i_s2    (r_s2),
        .i_coef  (r_coef),
        .o_s_new (w_s_new),
        .o_sat   (w_step_sat)
    );

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_ACCUM;
            ST_ACCUM: if (w_last)  w_next = ST_PWR1;
            ST_PWR1:  w_next = ST_PWR2;
            ST_PWR2:  w_next = ST_DONE;
            ST_DONE:  if (m_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register; status outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            s_ready <= (w_next == ST_ACCUM);
            busy    <= (w_next != ST_IDLE);
            m_valid <= (w_next == ST_DONE);
        end
    end

    // Block setup and recurrence state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n     <= '0;
            r_coef  <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_start) begin
            r_n     <= block_len;
            r_coef  <= coef;
            r_s1    <= '0;
            r_s2    <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_s1    <= w_s_new;
            r_s2    <= r_s1;
            r_count <= r_count + LEN_W'(1);
            r_sat   <= r_sat | w_step_sat;
        end
    end

    // Power pipeline: products in PWR1, combine and clamp in PWR2
    assign w_fb1  = (FB_W'(r_coef) * FB_W'(r_s1)) >>> COEF_FRAC;
    assign w_psum = P_SUM_W'(r_sq1) + P_SUM_W'(r_sq2) - P_SUM_W'(r_cross);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq1   <= '0;
            r_sq2   <= '0;
            r_cross <= '0;
            m_power <= '0;
            m_sat   <= 1'b0;
        end else begin
            if (r_state == ST_PWR1) begin
                r_sq1   <= SQ_W'(r_s1) * SQ_W'(r_s1);
                r_sq2   <= SQ_W'(r_s2) * SQ_W'(r_s2);
                r_cross <= X_W'(w_fb1) * X_W'(r_s2);
            end
            if (r_state == ST_PWR2) begin
                // Floor rounding in the cross term can push a true zero negative
                if (w_psum < 0) m_power <= '0;
                else            m_power <= PWR_W'(w_psum);
                m_sat <= r_sat;
            end
        end
    end

`ifdef TONE_IQ_OUT_EN
    logic signed [COEF_W-1:0] r_sin;
    logic signed [ACC_W:0]    r_re;
    logic signed [ACC_W:0]    r_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin <= '0;
            r_re  <= '0;
            r_im  <= '0;
            m_re  <= '0;
            m_im  <= '0;
        end else begin
            if (w_start) r_sin <= sin_coef;
            if (r_state == ST_PWR1) begin
                // coef is 2*cos, so one extra shift gives cos*s2
                r_re <= (ACC_W+1)'(r_s1)
                      - (ACC_W+1)'((FB_W'(r_coef) * FB_W'(r_s2)) >>> (COEF_FRAC + 1));
                r_im <= (ACC_W+1)'((FB_W'(r_sin) * FB_W'(r_s2)) >>> COEF_FRAC);
            end
            if (r_state == ST_PWR2) begin
                m_re <= r_re;
                m_im <= r_im;
            end
        end
    end
`endif

endmodule
